// File: rtl/audio_to_axi_pkg.sv
// ============================================================================
// Module : audio_to_axi_pkg
// Brief  : Register map, bit positions and response codes for the audio
//          capture/playback AXI4-Lite register blocks.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package audio_to_axi_pkg;

  // Decoded from addr[3:2]; byte offsets are 0x0, 0x4, 0x8, 0xC.
  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_STATUS = 2'd1,
    REG_LEFT   = 2'd2,
    REG_RIGHT  = 2'd3
  } reg_sel_e;

  localparam int CTRL_ENABLE    = 0;
  localparam int CTRL_FLUSH     = 1;
  localparam int CTRL_IRQ_EN    = 2;

  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVERFLOW  = 2;
  localparam int STAT_LEVEL_LSB = 8;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  function automatic reg_sel_e addr_to_sel(input logic [1:0] word_addr);
    return reg_sel_e'(word_addr);
  endfunction

endpackage

`default_nettype wire

// File: rtl/audio_to_axi_if.sv
// ============================================================================
// Module : audio_to_axi_if
// Brief  : AXI4-Lite register bus bundle with master and slave views.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface audio_to_axi_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

`default_nettype wire

// File: rtl/audio_to_axi_sample_fifo.sv
// ============================================================================
// Module : sample_fifo
// Brief  : Stereo sample FIFO, synchronous write with combinational head.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sample_fifo #(
  parameter int WIDTH = 48,
  parameter int AW    = 4
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             push,
  input  wire logic             pop,
  input  wire logic             flush,
  input  wire logic [WIDTH-1:0] din,
  output logic      [WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic      [AW:0]      level
);

  logic [WIDTH-1:0] r_mem [2**AW];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign w_push = push & ~full & ~flush;
  assign w_pop  = pop & ~empty & ~flush;

  // Extra MSB on each pointer separates the wrapped-full case from empty.
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign level = r_wr_ptr - r_rd_ptr;
  assign dout  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/audio_to_axi.sv
// ============================================================================
// Module : audio_to_axi
// Brief  : AXI4-Lite slave capturing stereo audio into a FIFO drained by reads.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module audio_to_axi
  import audio_to_axi_pkg::*;
#(
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter int C_S00_AXI_ADDR_WIDTH = 4,
  parameter int SAMPLE_W             = 24,
  parameter int FIFO_AW              = 4
) (
  input  wire logic                s00_axi_aclk,
  input  wire logic                s00_axi_aresetn,
  input  wire logic                audio_valid,
  input  wire logic [SAMPLE_W-1:0] audio_l,
  input  wire logic [SAMPLE_W-1:0] audio_r,
  audio_to_axi_if.slave            s00_axi,
  output logic                     irq
);

  localparam int DW = C_S00_AXI_DATA_WIDTH;

  logic          r_awready, r_bvalid, r_arready, r_rvalid;
  logic [DW-1:0] r_rdata;
  logic          r_enable, r_irq_en, r_ovf, r_irq;

  logic                 w_wr_start, w_wr_fire, w_rd_fire;
  reg_sel_e             w_wsel, w_rsel;
  logic                 w_ctrl_wr, w_flush, w_ovf_clr;
  logic                 w_push_req, w_push, w_pop, w_ovf_set;
  logic                 w_full, w_empty;
  logic [FIFO_AW:0]     w_level;
  logic [2*SAMPLE_W-1:0] w_head;
  logic signed [SAMPLE_W-1:0] w_head_l, w_head_r;
  logic [DW-1:0]        w_status, w_rd_val;
  logic                 w_unused;

  assign w_wsel     = addr_to_sel(s00_axi.awaddr[3:2]);
  assign w_rsel     = addr_to_sel(s00_axi.araddr[3:2]);
  assign w_wr_start = s00_axi.awvalid & s00_axi.wvalid & ~r_bvalid & ~r_awready;
  assign w_wr_fire  = r_awready & s00_axi.awvalid & s00_axi.wvalid;
  assign w_rd_fire  = r_arready & s00_axi.arvalid;

  assign w_ctrl_wr  = w_wr_fire && (w_wsel == REG_CTRL) && s00_axi.wstrb[0];
  assign w_flush    = w_ctrl_wr & s00_axi.wdata[CTRL_FLUSH];
  assign w_ovf_clr  = w_wr_fire && (w_wsel == REG_STATUS) && s00_axi.wstrb[0] &&
                      s00_axi.wdata[STAT_OVERFLOW];

  // Full is judged on pre-pop state, so a push against a full FIFO drops
  // even when a RIGHT read frees an entry on the same edge.
  assign w_push_req = audio_valid & r_enable;
  assign w_push     = w_push_req & ~w_full & ~w_flush;
  assign w_ovf_set  = w_push_req & w_full;
  assign w_pop      = w_rd_fire && (w_rsel == REG_RIGHT) && !w_empty;

  sample_fifo #(
    .WIDTH (2*SAMPLE_W),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (s00_axi_aclk),
    .rst_n (s00_axi_aresetn),
    .push  (w_push),
    .pop   (w_pop),
    .flush (w_flush),
    .din   ({audio_l, audio_r}),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .level (w_level)
  );

  assign w_head_l = w_head[2*SAMPLE_W-1:SAMPLE_W];
  assign w_head_r = w_head[SAMPLE_W-1:0];

  always_comb begin
    w_status                                = '0;
    w_status[STAT_EMPTY]                    = w_empty;
    w_status[STAT_FULL]                     = w_full;
    w_status[STAT_OVERFLOW]                 = r_ovf;
    w_status[STAT_LEVEL_LSB +: FIFO_AW+1]   = w_level;
  end

  always_comb begin
    w_rd_val = '0;
    case (w_rsel)
      REG_CTRL: begin
        w_rd_val[CTRL_ENABLE] = r_enable;
        w_rd_val[CTRL_IRQ_EN] = r_irq_en;
      end
      REG_STATUS: w_rd_val = w_status;
      REG_LEFT:   w_rd_val = w_empty ? '0 : DW'(w_head_l);
      REG_RIGHT:  w_rd_val = w_empty ? '0 : DW'(w_head_r);
      default:    w_rd_val = '0;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_enable  <= 1'b0;
      r_irq_en  <= 1'b0;
      r_ovf     <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_awready <= w_wr_start;
      if (w_wr_fire)           r_bvalid <= 1'b1;
      else if (s00_axi.bready) r_bvalid <= 1'b0;

      r_arready <= s00_axi.arvalid & ~r_rvalid & ~r_arready;
      if (w_rd_fire) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_val;
      end else if (s00_axi.rready) begin
        r_rvalid <= 1'b0;
      end

      if (w_ctrl_wr) begin
        r_enable <= s00_axi.wdata[CTRL_ENABLE];
        r_irq_en <= s00_axi.wdata[CTRL_IRQ_EN];
      end
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;

      r_irq <= r_irq_en & ~w_empty;
    end
  end

  assign s00_axi.awready = r_awready;
  assign s00_axi.wready  = r_awready;
  assign s00_axi.bvalid  = r_bvalid;
  assign s00_axi.bresp   = RESP_OKAY;
  assign s00_axi.arready = r_arready;
  assign s00_axi.rvalid  = r_rvalid;
  assign s00_axi.rdata   = r_rdata;
  assign s00_axi.rresp   = RESP_OKAY;
  assign irq             = r_irq;

  assign w_unused = ^{s00_axi.awprot, s00_axi.arprot, s00_axi.awaddr,
                      s00_axi.araddr, s00_axi.wdata, s00_axi.wstrb};

endmodule

`default_nettype wire

// File: tb/tb_audio_to_axi.sv
// ============================================================================
// Module : tb_audio_to_axi
// Brief  : Self-checking bench for the audio capture AXI4-Lite slave.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_audio_to_axi;
  localparam logic [3:0] A_CTRL = 4'h0, A_STAT = 4'h4, A_LEFT = 4'h8, A_RIGHT = 4'hC;
  localparam int TMO = 20;

  logic        tb_ACLK;
  logic        tb_ARESETN;
  logic        audio_valid;
  logic [23:0] audio_l, audio_r;
  logic        irq;

  audio_to_axi_if #(.ADDR_W(4), .DATA_W(32)) bus ();

  audio_to_axi #(
    .C_S00_AXI_DATA_WIDTH (32),
    .C_S00_AXI_ADDR_WIDTH (4),
    .SAMPLE_W             (24),
    .FIFO_AW              (4)
  ) dut (
    .s00_axi_aclk    (tb_ACLK),
    .s00_axi_aresetn (tb_ARESETN),
    .audio_valid     (audio_valid),
    .audio_l         (audio_l),
    .audio_r         (audio_r),
    .s00_axi         (bus.slave),
    .irq             (irq)
  );

  initial tb_ACLK = 1'b0;
  always #5 tb_ACLK = ~tb_ACLK;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       nm;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic [31:0] exp_l;
    logic [31:0] exp_r;
  } vec_t;
  vec_t vecs[3];

  logic [47:0] model_q[$];
  bit          model_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: actual=timeout required=handshake", nm);
  endtask

  task automatic tick();
    @(posedge tb_ACLK);
    #1;
  endtask

  function automatic logic [31:0] sext(input logic [23:0] v);
    return {{8{v[23]}}, v};
  endfunction

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int n;
    bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    n = 0;
    while (!bus.awready && n < TMO) begin tick(); n++; end
    if (!bus.awready) begin
      timeout("awready");
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      return;
    end
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    n = 0;
    while (!bus.bvalid && n < TMO) begin tick(); n++; end
    if (!bus.bvalid) begin timeout("bvalid"); return; end
    chk("bresp", {30'd0, bus.bresp}, 32'd0);
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
    int n;
    data = 32'hxxxx_xxxx;
    bus.araddr = addr; bus.arvalid = 1'b1;
    n = 0;
    while (!bus.arready && n < TMO) begin tick(); n++; end
    if (!bus.arready) begin timeout("arready"); bus.arvalid = 1'b0; return; end
    tick();
    bus.arvalid = 1'b0;
    n = 0;
    while (!bus.rvalid && n < TMO) begin tick(); n++; end
    if (!bus.rvalid) begin timeout("rvalid"); return; end
    data = bus.rdata;
    chk("rresp", {30'd0, bus.rresp}, 32'd0);
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
  endtask

  task automatic rd_check(input logic [3:0] addr, input logic [31:0] exp, input string nm);
    logic [31:0] d;
    sb_t e;
    sb_q.push_back('{nm, exp});
    axi_read(addr, d);
    e = sb_q.pop_front();
    chk(e.nm, d, e.exp);
  endtask

  task automatic push_sample(input logic [23:0] l, input logic [23:0] r);
    audio_l = l; audio_r = r; audio_valid = 1'b1;
    tick();
    audio_valid = 1'b0;
    if (model_en && model_q.size() < 16) model_q.push_back({l, r});
  endtask

  task automatic pop_right(input string nm);
    logic [31:0] exp;
    if (model_q.size() == 0) exp = 32'd0;
    else exp = sext(model_q.pop_front()[23:0]);
    rd_check(A_RIGHT, exp, nm);
  endtask

  // Lines a sample strobe up with the edge that accepts a RIGHT read.
  task automatic coin_pop(input logic [23:0] l, input logic [23:0] r, input string nm);
    int n;
    logic [31:0] exp;
    bit was_full;
    was_full = (model_q.size() == 16);
    exp = (model_q.size() == 0) ? 32'd0 : sext(model_q[0][23:0]);
    bus.araddr = A_RIGHT; bus.arvalid = 1'b1;
    n = 0;
    while (!bus.arready && n < TMO) begin tick(); n++; end
    if (!bus.arready) begin timeout("coin_arready"); bus.arvalid = 1'b0; return; end
    audio_l = l; audio_r = r; audio_valid = 1'b1;
    tick();
    audio_valid = 1'b0; bus.arvalid = 1'b0;
    if (model_q.size() > 0) void'(model_q.pop_front());
    if (model_en && !was_full) model_q.push_back({l, r});
    n = 0;
    while (!bus.rvalid && n < TMO) begin tick(); n++; end
    if (!bus.rvalid) begin timeout("coin_rvalid"); return; end
    chk(nm, bus.rdata, exp);
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    vecs[0] = '{24'h7FFFFF, 24'h800000, 32'h007FFFFF, 32'hFF800000};
    vecs[1] = '{24'h000001, 24'hFFFFFF, 32'h00000001, 32'hFFFFFFFF};
    vecs[2] = '{24'h123456, 24'h654321, 32'h00123456, 32'h00654321};

    tb_ARESETN = 1'b0; audio_valid = 1'b0; audio_l = '0; audio_r = '0;
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    repeat (3) tick();
    chk("reset_outputs",
        {26'd0, bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, irq}, 32'd0);
    chk("reset_rdata", bus.rdata, 32'd0);
    tb_ARESETN = 1'b1;
    tick();

    rd_check(A_CTRL,  32'h0, "reset_ctrl");
    rd_check(A_STAT,  32'h1, "reset_status");
    rd_check(A_LEFT,  32'h0, "reset_left");
    rd_check(A_RIGHT, 32'h0, "reset_right");

    // Table: three samples in, then LEFT/RIGHT pairs with level after each pop.
    axi_write(A_CTRL, 32'h1, 4'hF);
    model_en = 1'b1;
    for (int i = 0; i < 3; i++) push_sample(vecs[i].l, vecs[i].r);
    rd_check(A_STAT, 32'h0000_0300, "level3");
    for (int i = 0; i < 3; i++) begin
      rd_check(A_LEFT,  vecs[i].exp_l, $sformatf("vec%0d_left", i));
      rd_check(A_RIGHT, vecs[i].exp_r, $sformatf("vec%0d_right", i));
      void'(model_q.pop_front());
      rd_check(A_STAT, ((32'd2 - i) << 8) | ((i == 2) ? 32'h1 : 32'h0),
               $sformatf("vec%0d_status", i));
    end

    for (int i = 0; i < 16; i++) push_sample(24'(i), 24'(32'h100 + i));
    rd_check(A_STAT, 32'h0000_1002, "full16");
    push_sample(24'hDEAD01, 24'hDEAD02);
    rd_check(A_STAT, 32'h0000_1006, "full_overflow");
    axi_write(A_STAT, 32'h4, 4'hF);
    rd_check(A_STAT, 32'h0000_1002, "ovf_cleared");

    axi_write(A_CTRL, 32'h5, 4'hF);
    tick();
    chk("irq_on", {31'd0, irq}, 32'd1);

    for (int i = 0; i < 11; i++) pop_right($sformatf("drain_a%0d", i));
    rd_check(A_STAT, 32'h0000_0500, "level5");
    coin_pop(24'h0000AA, 24'h0000BB, "coin5_right");
    rd_check(A_STAT, 32'h0000_0500, "coin5_level");

    for (int i = 0; i < 11; i++) push_sample(24'(32'h300 + i), 24'(32'h200 + i));
    rd_check(A_STAT, 32'h0000_1002, "refill16");
    coin_pop(24'h0000CC, 24'h0000DD, "coin16_right");
    rd_check(A_STAT, 32'h0000_0F04, "coin16_status");
    axi_write(A_STAT, 32'h4, 4'h2);
    rd_check(A_STAT, 32'h0000_0F04, "ovf_wstrb0");
    axi_write(A_STAT, 32'h4, 4'h1);
    rd_check(A_STAT, 32'h0000_0F00, "ovf_wstrb1");

    for (int i = 0; i < 7; i++) pop_right($sformatf("drain_b%0d", i));
    rd_check(A_STAT, 32'h0000_0800, "level8");
    rd_check(A_LEFT, sext(model_q[0][47:24]), "peek_left");
    axi_write(A_CTRL, 32'h3, 4'hF);
    model_q.delete();
    rd_check(A_STAT, 32'h1, "flush_status");
    rd_check(A_CTRL, 32'h1, "flush_ctrl");
    chk("irq_off", {31'd0, irq}, 32'd0);

    axi_write(A_CTRL, 32'h0, 4'hF);
    model_en = 1'b0;
    push_sample(24'h111111, 24'h222222);
    rd_check(A_STAT, 32'h1, "disabled_push");
    axi_write(A_CTRL, 32'h1, 4'hF);
    model_en = 1'b1;

    // Backpressure: B and R both held, then reset while holding.
    push_sample(24'h000400, 24'h800000);
    bus.awaddr = A_CTRL; bus.wdata = 32'h1; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    n = 0;
    while (!bus.awready && n < TMO) begin tick(); n++; end
    if (!bus.awready) timeout("bp_awready");
    tick();
    bus.araddr = A_STAT; bus.arvalid = 1'b1;
    n = 0;
    while (!bus.arready && n < TMO) begin tick(); n++; end
    if (!bus.arready) timeout("bp_arready");
    tick();
    bus.arvalid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp_hold%0d", i), {29'd0, bus.bvalid, bus.rvalid, bus.awready}, 32'b110);
      chk($sformatf("bp_rdata%0d", i), bus.rdata, 32'h0000_0100);
      tick();
    end
    #3;
    tb_ARESETN = 1'b0;
    #1;
    chk("async_reset",
        {27'd0, bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid}, 32'd0);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    tick();
    tb_ARESETN = 1'b1;
    model_q.delete();
    model_en = 1'b0;
    tick();
    rd_check(A_STAT, 32'h1, "post_reset_status");
    rd_check(A_CTRL, 32'h0, "post_reset_ctrl");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/audio_to_axi.md
# audio_to_axi

AXI4-Lite slave that captures stereo samples from the audio path into a small FIFO and lets the processor drain them over register reads. It is the capture-direction counterpart of axi_to_audio: the same S00_AXI register bus, with data flowing audio → CPU. It sits between the mixer/ADC sample stream and the PS interconnect.

## Interface
- C_S00_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- C_S00_AXI_ADDR_WIDTH, 4, byte address width, covering 4 registers.
- SAMPLE_W, 24, width of audio_l/audio_r, valid range 8..32.
- FIFO_AW, 4, log2 of FIFO depth; 16 L/R entries by default.

Ports:
- s00_axi_aclk in 1: the only clock.
- s00_axi_aresetn in 1: asynchronous, active-low reset.
- audio_valid in 1: one-cycle strobe marking a new stereo sample.
- audio_l, audio_r in SAMPLE_W: signed samples.
- s00_axi_awaddr in ADDR_W, s00_axi_awprot in 3 (ignored), s00_axi_awvalid in 1, s00_axi_awready out 1.
- s00_axi_wdata in 32, s00_axi_wstrb in 4, s00_axi_wvalid in 1, s00_axi_wready out 1.
- s00_axi_bresp out 2, s00_axi_bvalid out 1, s00_axi_bready in 1.
- s00_axi_araddr in ADDR_W, s00_axi_arprot in 3 (ignored), s00_axi_arvalid in 1, s00_axi_arready out 1.
- s00_axi_rdata out 32, s00_axi_rresp out 2, s00_axi_rvalid out 1, s00_axi_rready in 1.
- irq out 1: level output, high when STATUS.empty=0 and CTRL.irq_en=1.

## Operation
- Register map (byte offsets; only addr[3:2] is decoded):
  - 0x0 CTRL (RW): bit0 enable, bit1 flush (write 1; self-clearing, reads as 0), bit2 irq_en. Other bits read as 0.
  - 0x4 STATUS (RO, except bit2): bit0 empty, bit1 full, bit2 overflow (sticky; write 1 to clear), bits[15:8] level (0..2^FIFO_AW).
  - 0x8 LEFT (RO): peeks the left sample at the FIFO head, sign-extended to 32 bits. Does not pop.
  - 0xC RIGHT (RO): returns the right sample at the head, sign-extended, and pops the entry.
- Reading LEFT or RIGHT while the FIFO is empty returns 0, does not pop, and does not raise an error.
- Push: when audio_valid=1 and enable=1 and full=0, {audio_l, audio_r} is written at the tail.
  - audio_valid=1 with enable=1 and full=1 drops the sample and sets overflow.
  - audio_valid=1 with enable=0 is ignored; overflow is not set.
- Full is evaluated before any same-cycle pop, so a push while full is dropped even if a RIGHT pop is accepted in that cycle.
- Simultaneous push and pop with the FIFO not full: both take effect and level is unchanged.
- Flush empties the FIFO (pointers and level to 0) in the cycle after the write is accepted. It does not clear overflow.
  - If flush coincides with a push, flush wins and the sample is discarded.
- WSTRB: CTRL bits update only when wstrb[0]=1; overflow clear requires wstrb[0]=1.
- Writes to 0x8 and 0xC are ignored.
- bresp and rresp are always 2'b00 (OKAY).

## Timing
- Reset values: all ready/valid outputs 0, rdata 0, resp 0, irq 0, CTRL 0, FIFO empty, overflow 0.
- Write channel:
  - awready and wready rise together for exactly one cycle N when awvalid=1, wvalid=1 and bvalid=0.
  - The register update is visible from N+1. bvalid=1 from N+1 and is held until bready=1.
  - No new write is accepted while bvalid=1.
- Read channel:
  - arready is high for one cycle N when arvalid=1 and rvalid=0.
  - rdata is captured at N from the register state before any same-cycle write. rvalid=1 from N+1.
  - rdata and rvalid are held stable until rready=1.
  - The RIGHT pop occurs at N; STATUS.level reflects it from N+1.
- Push latency: a sample strobed at cycle N is readable, and counted in level, from N+1.
- irq follows STATUS with one cycle of latency (registered).
- Reset asserted mid-transaction: all channels return to idle immediately and the FIFO contents are discarded. No response is issued for an in-flight transaction.

## Structure
- Shared package/include axi_audio_defs holds:
  - register offsets (CTRL/STATUS/LEFT/RIGHT);
  - CTRL and STATUS bit positions;
  - the RESP_OKAY constant.
- The axi_to_audio register logic uses the same definitions.
- One sub-module: sample_fifo.
  - Synchronous-write, combinational-read-head FIFO of width 2*SAMPLE_W and depth 2^FIFO_AW.
  - Ports: push, pop, flush, full, empty, level.
  - Uses an extra pointer bit to distinguish full from empty.
- The top level holds the AXI handshake registers, the register decode and the sign extension.

## Test plan
- Reset then read all 4 registers: CTRL=0x0, STATUS=0x00000001, LEFT=0, RIGHT=0, all with resp OKAY.
- Write CTRL=0x1, strobe 3 samples (L=0x7FFFFF, R=0x800000; L=0x000001, R=0xFFFFFF; L=0x123456, R=0x654321):
  - STATUS.level=3;
  - the first LEFT/RIGHT pair reads 0x007FFFFF / 0xFF800000;
  - after that RIGHT read, level=2.
- Fill to 16, then strobe 1 more: STATUS=0x00001006 (full + overflow, level 16). Write STATUS=0x4 → overflow clears and level stays 16.
- Push and RIGHT pop in the same cycle with level=5: level stays 5. Repeat at level=16: the push is dropped, overflow sets, level=15.
- Write CTRL=0x3 at level 8: next STATUS=0x00000001 and CTRL reads 0x1.
- Backpressure: hold bready=0 and rready=0 for 10 cycles.
  - bvalid and rvalid stay high, with rdata stable.
  - A second awvalid/wvalid pair gets no awready until B completes.
  - Assert reset mid-hold: all valids drop within 0 cycles (asynchronous).
